// File: rtl/scan_cycle_ctrl_pkg.sv
// Shared definitions for the PLC scan-cycle controller: default widths and
// the 3-bit scan state encoding.
package scan_cycle_ctrl_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_WDT_W = 16;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_UPDATE = 3'd4,
    ST_FAULT  = 3'd5
  } scan_state_t;

endpackage

// File: rtl/scan_cycle_ctrl_if.sv
// Controller <-> instruction-list core link: input image, output register,
// restart/run controls and the end-of-program pulse.
interface scan_cycle_ctrl_if
  import scan_cycle_ctrl_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
);

  logic [IN_W-1:0]  in_image;
  logic [OUT_W-1:0] out_image;
  logic             cpu_restart;
  logic             cpu_run;
  logic             cpu_end;

  modport master (
    output in_image,
    output cpu_restart,
    output cpu_run,
    input  out_image,
    input  cpu_end
  );

  modport slave (
    input  in_image,
    input  cpu_restart,
    input  cpu_run,
    output out_image,
    output cpu_end
  );

endinterface

// File: rtl/scan_cycle_ctrl_sync2.sv
// Parameterized two-flop synchronizer bringing the raw input pins into the
// clk domain before they are sampled into the input image.
module sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: every flop here and in the controller is cleared by the async reset;
  // there are no storage arrays, so nothing is left uninitialised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/scan_cycle_ctrl.sv
// PLC scan-cycle controller: sample inputs, restart and run the core until END,
// commit outputs, and drop to a safe output state if a scan overruns the watchdog.
module scan_cycle_ctrl
  import scan_cycle_ctrl_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int WDT_W = DEF_WDT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_en,
  input  logic [IN_W-1:0]       in_pins,
  scan_cycle_ctrl_if.master     core,
  output logic [OUT_W-1:0]      out_pins,
  input  logic [WDT_W-1:0]      wdt_limit,
  input  logic                  fault_clr,
  output logic                  scan_done,
  output logic                  wdt_fault,
  output logic [CNT_W-1:0]      scan_count
);

  logic [IN_W-1:0]  in_sync;
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_expire;
  scan_state_t      state;
  scan_state_t      next_state;

  sync2 #(.W(IN_W)) u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (in_pins),
    .q     (in_sync)
  );

  // The counter holds (RUN cycles so far - 1), so equality with limit-1
  // fires on the limit-th RUN cycle; a zero limit disables the check.
  always_comb begin
    wdt_expire = (wdt_limit != '0) && (wdt_cnt == wdt_limit - WDT_W'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state is given its default before the case, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (scan_en) next_state = ST_SAMPLE;
      ST_SAMPLE: next_state = ST_START;
      ST_START:  next_state = ST_RUN;
      ST_RUN: begin
        if (core.cpu_end)    next_state = ST_UPDATE;
        else if (wdt_expire) next_state = ST_FAULT;
      end
      ST_UPDATE: next_state = scan_en ? ST_SAMPLE : ST_IDLE;
      ST_FAULT:  if (fault_clr) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Level outputs are registered from next_state so they line up with the
  // state; per-state actions (image capture, commit, count) land a cycle later.
  // NOTE: non-blocking assignments throughout, so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core.in_image    <= '0;
      core.cpu_restart <= 1'b0;
      core.cpu_run     <= 1'b0;
      out_pins         <= '0;
      scan_done        <= 1'b0;
      wdt_fault        <= 1'b0;
      scan_count       <= '0;
      wdt_cnt          <= '0;
    end else begin
      core.cpu_restart <= (next_state == ST_START);
      core.cpu_run     <= (next_state == ST_RUN);
      wdt_fault        <= (next_state == ST_FAULT);
      scan_done        <= (state == ST_UPDATE);

      if (state == ST_SAMPLE) core.in_image <= in_sync;

      if (state == ST_START)
        wdt_cnt <= '0;
      else if (state == ST_RUN && wdt_cnt != '1)
        wdt_cnt <= wdt_cnt + WDT_W'(1);

      if (state == ST_UPDATE) begin
        out_pins   <= core.out_image;
        scan_count <= scan_count + CNT_W'(1);
      end else if (next_state == ST_FAULT) begin
        out_pins   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_scan_cycle_ctrl.sv
// Self-checking bench for scan_cycle_ctrl: a cycle-offset scan model checked on
// every cycle, directed scenarios with literal expectations, and random traffic.
module tb_scan_cycle_ctrl;

  localparam int IN_W  = 8;
  localparam int OUT_W = 8;
  localparam int WDT_W = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             scan_en;
  logic [IN_W-1:0]  in_pins;
  logic [OUT_W-1:0] out_pins;
  logic [WDT_W-1:0] wdt_limit;
  logic             fault_clr;
  logic             scan_done;
  logic             wdt_fault;
  logic [CNT_W-1:0] scan_count;

  scan_cycle_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) core ();

  scan_cycle_ctrl #(
    .IN_W(IN_W), .OUT_W(OUT_W), .WDT_W(WDT_W), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_en    (scan_en),
    .in_pins    (in_pins),
    .core       (core),
    .out_pins   (out_pins),
    .wdt_limit  (wdt_limit),
    .fault_clr  (fault_clr),
    .scan_done  (scan_done),
    .wdt_fault  (wdt_fault),
    .scan_count (scan_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- core stand-in: ends the program after end_after RUN cycles
  int              end_after = 10;   // 0: never signal END
  int              run_cnt   = 0;
  bit              noise     = 0;    // stray cpu_end pulses outside RUN
  bit              img_rand  = 0;
  logic [OUT_W-1:0] fixed_img = 8'h3C;

  always @(negedge clk) begin
    core.out_image = img_rand ? OUT_W'($urandom) : fixed_img;
    core.cpu_end   = 1'b0;
    if (core.cpu_run) begin
      run_cnt++;
      if (end_after > 0 && run_cnt >= end_after) core.cpu_end = 1'b1;
    end else begin
      run_cnt = 0;
      if (noise && $urandom_range(0, 7) == 0) core.cpu_end = 1'b1;
    end
  end

  // ---------------- reference model: each scan is located by its "cycle 0" t0
  // (SAMPLE at t0+1, restart at t0+2, RUN from t0+3) and the END cycle t_end
  // (UPDATE at t_end+1, which is also cycle 0 of a following scan).
  localparam int M_IDLE = 0, M_SCAN = 1, M_FAULT = 2;
  int               cyc = 0, mode = M_IDLE, t0 = 0, t_end = -1, last_rst = 0;
  logic [IN_W-1:0]  pin_log [int];
  logic [IN_W-1:0]  exp_in_image = '0;
  logic [OUT_W-1:0] exp_out_pins = '0;
  logic [CNT_W-1:0] exp_count    = '0;
  bit exp_restart = 0, exp_run = 0, exp_done = 0, exp_fault = 0;

  always @(posedge clk) begin : model
    int p, off;
    bit was_update;
    p   = cyc;             // cycle that just ended; its inputs are sampled now
    cyc = cyc + 1;         // cycle that is starting
    pin_log[p] = in_pins;
    was_update = 0;
    if (reset) begin
      last_rst = cyc;
      mode = M_IDLE; t_end = -1;
      exp_in_image = '0; exp_out_pins = '0; exp_count = '0;
    end else begin
      case (mode)
        M_IDLE: if (scan_en) begin mode = M_SCAN; t0 = p; t_end = -1; end
        M_FAULT: if (fault_clr) mode = M_IDLE;
        default: begin
          off = p - t0;
          if (t_end >= 0 && p == t_end + 1) begin
            was_update   = 1;
            exp_out_pins = core.out_image;
            exp_count    = exp_count + 1'b1;
            if (scan_en) begin t0 = p; t_end = -1; end
            else mode = M_IDLE;
          end else if (off == 1) begin
            exp_in_image = (last_rst >= p - 1) ? '0 : pin_log[p-2];
          end else if (off >= 3 && t_end < 0) begin
            if (core.cpu_end) t_end = p;
            else if (wdt_limit != 0 && off - 2 == int'(wdt_limit)) begin
              mode = M_FAULT;
              exp_out_pins = '0;
            end
          end
        end
      endcase
    end
    exp_done    = was_update;
    exp_fault   = (mode == M_FAULT);
    exp_restart = (mode == M_SCAN) && (t_end < 0) && (cyc - t0 == 2);
    exp_run     = (mode == M_SCAN) && (t_end < 0) && (cyc - t0 >= 3);
    #1;
    check("in_image",    core.in_image,    exp_in_image);
    check("out_pins",    out_pins,         exp_out_pins);
    check("scan_count",  scan_count,       exp_count);
    check("cpu_restart", core.cpu_restart, exp_restart);
    check("cpu_run",     core.cpu_run,     exp_run);
    check("scan_done",   scan_done,        exp_done);
    check("wdt_fault",   wdt_fault,        exp_fault);
  end

  // ---------------- bounded wait on a DUT output (0 done, 1 run, 2 fault, 3 restart)
  task automatic wait_sig(input string name, input int which, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = scan_done;
        1:       seen = core.cpu_run;
        2:       seen = wdt_fault;
        default: seen = core.cpu_restart;
      endcase
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int run_n, done_n;
    reset = 1'b1; scan_en = 1'b0; fault_clr = 1'b0; wdt_limit = '0;
    in_pins = 8'hA5;
    core.cpu_end = 1'b0; core.out_image = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", scan_count, 0);
    check("rst_out",   out_pins, 0);
    check("rst_img",   core.in_image, 0);
    check("rst_run",   core.cpu_run, 0);

    // basic scan: END after 10 RUN cycles
    scan_en = 1'b1;                                   // cycle 0
    @(negedge clk); check("c1_no_restart", core.cpu_restart, 0);
    @(negedge clk); check("c2_img", core.in_image, 8'hA5);
                    check("c2_restart", core.cpu_restart, 1);
    @(negedge clk); check("c3_run", core.cpu_run, 1);
    repeat (11) @(negedge clk);                       // k = 12, now k+2
    check("k2_out", out_pins, 8'h3C);
    check("k2_done", scan_done, 1);
    check("k2_count", scan_count, 1);
    @(negedge clk); check("k3_restart", core.cpu_restart, 1);

    // input stability: change pins during RUN
    @(negedge clk);
    in_pins = 8'h5A;
    repeat (5) @(negedge clk);
    check("img_stable", core.in_image, 8'hA5);
    wait_sig("next_restart", 3, 50);
    check("img_new", core.in_image, 8'h5A);

    // watchdog: no END, limit 20
    wdt_limit = 20; end_after = 0;
    run_n = 0;
    for (int i = 0; i < 100 && !wdt_fault; i++) begin
      if (core.cpu_run) run_n++;
      @(negedge clk);
    end
    check("wdt_run_cycles", run_n, 20);
    check("wdt_fault_set", wdt_fault, 1);
    check("wdt_safe_out", out_pins, 0);
    end_after = 5;
    repeat (3) @(negedge clk);
    check("wdt_sticky", wdt_fault, 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("wdt_cleared", wdt_fault, 0);
    check("wdt_safe_hold", out_pins, 0);
    wait_sig("resume_done", 0, 60);
    check("resume_out", out_pins, 8'h3C);

    // race: END on the cycle the watchdog would expire
    scan_en = 1'b0;
    repeat (30) @(negedge clk);
    wdt_limit = 7; end_after = 7; scan_en = 1'b1;
    wait_sig("race_done", 0, 60);
    check("race_no_fault", wdt_fault, 0);

    // watchdog disabled: a long scan never faults
    wdt_limit = 0; end_after = 0;
    repeat (300) @(negedge clk);
    check("nolimit_no_fault", wdt_fault, 0);
    check("nolimit_running", core.cpu_run, 1);
    end_after = 1;
    wait_sig("nolimit_end", 0, 10);

    // stop mid-RUN: the scan completes, then the block parks
    end_after = 15;
    wait_sig("stop_restart", 3, 10);
    repeat (5) @(negedge clk);
    scan_en = 1'b0;
    done_n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (scan_done) done_n++;
    end
    check("stop_one_done", done_n, 1);
    check("stop_parked_run", core.cpu_run, 0);
    check("stop_parked_restart", core.cpu_restart, 0);

    // asynchronous reset mid-RUN
    scan_en = 1'b1;
    wait_sig("rst_run", 1, 30);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_img", core.in_image, 0);
    check("arst_out", out_pins, 0);
    check("arst_run", core.cpu_run, 0);
    check("arst_restart", core.cpu_restart, 0);
    check("arst_done", scan_done, 0);
    check("arst_fault", wdt_fault, 0);
    check("arst_count", scan_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // randomized traffic against the model
    img_rand = 1; noise = 1; wdt_limit = 25;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      in_pins   = IN_W'($urandom);
      scan_en   = ($urandom_range(0, 9) != 0);
      fault_clr = ($urandom_range(0, 4) == 0);
      if (!core.cpu_run) end_after = $urandom_range(1, 30);
      if ($urandom_range(0, 99) == 0)
        wdt_limit = ($urandom_range(0, 3) == 0) ? '0 : WDT_W'($urandom_range(1, 30));
    end

    // counter wrap with a 4-bit scan count
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    img_rand = 0; noise = 0; fault_clr = 1'b0; wdt_limit = '0; end_after = 3; scan_en = 1'b1;
    done_n = 0;
    for (int i = 0; i < 2000 && done_n < 17; i++) begin
      @(negedge clk);
      if (scan_done) done_n++;
    end
    check("wrap_scans", done_n, 17);
    check("wrap_count", scan_count, 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_cycle_ctrl.md
# scan_cycle_ctrl

PLC scan-cycle controller that sequences the instruction-list processor core through the classic read-inputs / execute / write-outputs loop. It samples the external input pins into a stable input image, restarts and runs the core until it signals end-of-program, then commits the core's output register to the pins. A watchdog forces the outputs to a safe state if a scan overruns. It sits in `top` between the `IN`/`OUT` pins and the processor core.

## Interface
- `IN_W`, 8, input pin count (matches `inputNumber`)
- `OUT_W`, 8, output pin count (matches `outputNumber`)
- `WDT_W`, 16, watchdog counter width
- `CNT_W`, 16, scan counter width

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `scan_en`  in  1  enable cyclic scanning
- `in_pins`  in  IN_W  raw, asynchronous input pins
- `in_image`  out  IN_W  input image presented to core, stable for a whole scan
- `out_image`  in  OUT_W  core output register
- `out_pins`  out  OUT_W  registered output pins
- `cpu_restart`  out  1  one-cycle pulse: core PC to 0, core flags cleared
- `cpu_run`  out  1  core execution enable
- `cpu_end`  in  1  core executed END (pulse, ≥1 cycle)
- `wdt_limit`  in  WDT_W  maximum RUN cycles per scan; 0 disables watchdog
- `fault_clr`  in  1  clear watchdog fault
- `scan_done`  out  1  one-cycle pulse per completed scan
- `wdt_fault`  out  1  sticky watchdog fault
- `scan_count`  out  CNT_W  completed scans, wraps modulo 2^CNT_W

## Operation
- `in_pins` passes through a 2-flop synchronizer; only synchronized values are sampled.
- States: IDLE, SAMPLE, START, RUN, UPDATE, FAULT.
- IDLE: `cpu_run`=0. Go to SAMPLE when `scan_en`=1.
- SAMPLE: `in_image` ← synchronized inputs. Go to START.
- START: `cpu_restart`=1, watchdog counter ← 0. Go to RUN.
- RUN: `cpu_run`=1, counter +1 per cycle, saturating.
  - `cpu_end`=1 → UPDATE.
  - Otherwise, if `wdt_limit`≠0 and counter == `wdt_limit`−1 → FAULT.
  - `cpu_end` wins over a watchdog expiry in the same cycle.
- UPDATE: `out_pins` ← `out_image`, `scan_done` pulses, `scan_count` +1 (wraps). Go to SAMPLE if `scan_en`, else IDLE.
- FAULT: `out_pins` ← 0 (safe state), `wdt_fault`=1, `cpu_run`=0. Stay until `fault_clr`=1, then go to IDLE with `wdt_fault` cleared. `out_pins` stays 0 until the next UPDATE.
- Deasserting `scan_en` mid-scan does not abort; the current scan completes through UPDATE.
- `cpu_end` is ignored outside RUN. `fault_clr` is ignored outside FAULT.
- `in_image` changes only in SAMPLE. `out_pins` changes only in UPDATE or on entry to FAULT.

## Timing
- All outputs are registered. Reset values: `in_image`=0, `out_pins`=0, `cpu_run`=0, `cpu_restart`=0, `scan_done`=0, `wdt_fault`=0, `scan_count`=0, state=IDLE, synchronizer=0.
- Reset is asynchronous. Asserting it mid-scan immediately returns to IDLE with all of the above values.
- Cycle sequence, counting from the IDLE cycle that sees `scan_en`=1 as cycle 0:
  - cycle 1: SAMPLE
  - cycle 2: `in_image` valid, `cpu_restart`=1
  - cycle 3: `cpu_run`=1 (first RUN cycle)
- `cpu_end` sampled high in cycle k → `out_pins` updated, `scan_done`=1 and `scan_count` incremented in cycle k+2. With `scan_en` held, `cpu_restart` reasserts in cycle k+3.
- Watchdog: a scan of N RUN cycles without `cpu_end` faults when N == `wdt_limit`. `wdt_fault` and `out_pins`=0 appear the cycle after that.
- Pin-to-image latency: 2 synchronizer cycles plus wait for the next SAMPLE.

## Structure
- The state encoding (3-bit localparams) and the default widths go in the shared `defines.v`, alongside `inputNumber`/`outputNumber`.
- One sub-module: `sync2`, a parameterized 2-flop synchronizer for `in_pins`.
- Top FSM, watchdog counter and scan counter live in `scan_cycle_ctrl`; the implementation must stay within 400 lines of RTL.

## Test plan
- Basic scan: `in_pins`=8'hA5 held, `scan_en`=1, core model returns `out_image`=8'h3C and pulses `cpu_end` 10 cycles after `cpu_run` → `in_image`=8'hA5, `out_pins`=8'h3C, one `scan_done` pulse, `scan_count`=1, then `cpu_restart` again.
- Input stability: toggle `in_pins` during RUN → `in_image` unchanged until the next SAMPLE; new value captured the following scan.
- Watchdog: `wdt_limit`=20, `cpu_end` never asserted → `wdt_fault`=1 and `out_pins`=0 after 20 RUN cycles; `fault_clr` pulse → IDLE, fault cleared, scanning resumes. With `wdt_limit`=0 no fault ever occurs.
- Race: `cpu_end` on the same cycle the watchdog would expire → UPDATE taken, no fault, `scan_done`=1.
- Stop/reset: drop `scan_en` mid-RUN → scan completes and the block parks in IDLE with `cpu_run`=0. Assert `reset` mid-RUN → all outputs 0 asynchronously.
- Wrap: `CNT_W`=4, run 17 scans → `scan_count`=1.
